booth_mult_rr_scheduler: RTL and testbench

- Shares one pipelined 8x8 Booth multiplier between NREQ independent requesters.
- Round-robin arbitration and issue of one operation per cycle.
- Tracks requester IDs in an in-order tag FIFO and routes each product back to the requester that issued it.
- Sits between client datapaths and the multiplier; the multiplier's valid_in/valid_out pipeline is the shared resource.

---
 rtl/booth_mult_rr_scheduler_pkg.sv | 28 ++
 rtl/booth_tag_fifo.sv | 61 ++++++
 rtl/booth_mult_rr_scheduler.sv | 125 ++++++++++++
 tb/tb_booth_mult_rr_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_rr_scheduler_pkg.sv
// Shared definitions for the Booth multiplier round-robin scheduler.
// Holds the sign-mode encodings, a constant-foldable clog2 helper and the
// default requester-tag width.
package booth_mult_rr_scheduler_pkg;

    // sign_mode encoding: bit1 = multiplicand signed, bit0 = multiplier signed
    localparam logic [1:0] SIGN_UU = 2'b00;
    localparam logic [1:0] SIGN_US = 2'b01;
    localparam logic [1:0] SIGN_SU = 2'b10;
    localparam logic [1:0] SIGN_SS = 2'b11;

    // Ceiling log2; bounded loop so it folds in elaboration and synthesis.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int NREQ_DEFAULT = 4;
    // Width of a requester ID as carried in the tag FIFO.
    localparam int TAG_W = clog2(NREQ_DEFAULT);

endpackage

// File: rtl/booth_tag_fifo.sv
// Purpose: in-order FIFO of requester tags for operations inside the multiplier.
// Latency: push visible at head on the next cycle; count/empty/full are registered-pointer derived.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
// Ports: clk, rst (sync, active high); push/push_tag write side; pop/pop_tag read side
//        (pop_tag is the current head); empty, full, count status.
module booth_tag_fifo
    import booth_mult_rr_scheduler_pkg::*;
#(
    parameter int TAG_W = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    output logic [TAG_W-1:0]         pop_tag,
    output logic                     empty,
    output logic                     full,
    output logic [clog2(DEPTH):0]    count
);

    localparam int AW    = clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty; pointers wrap naturally.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == PTR_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_tag = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_tag;
        end
    end

endmodule

// File: rtl/booth_mult_rr_scheduler.sv
// Purpose: shares one pipelined Booth multiplier among NREQ requesters, round-robin, and routes products back.
// Latency: accept in cycle t -> mul_valid_in in t+1; mul_valid_out in cycle u -> rsp_valid in u+1.
// Backpressure: req_ready drops while MAX_OUT ops are in flight; responses cannot be stalled.
// Ports: clk, rst (sync, active high); req_valid/req_ready/req_a/req_b/req_mode per-requester
//        request side; rsp_valid/rsp_product one-hot response side; mul_* to/from the multiplier;
//        inflight outstanding count; err_orphan sticky flag for results with no tag outstanding.
module booth_mult_rr_scheduler
    import booth_mult_rr_scheduler_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    input  logic [NREQ*2-1:0]         req_mode,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [2*WIDTH-1:0]        rsp_product,
    output logic                      mul_valid_in,
    output logic [WIDTH-1:0]          mul_multiplicand,
    output logic [WIDTH-1:0]          mul_multiplier,
    output logic [1:0]                mul_sign_mode,
    input  logic [2*WIDTH-1:0]        mul_product,
    input  logic                      mul_valid_out,
    output logic [clog2(MAX_OUT):0]   inflight,
    output logic                      err_orphan
);

    localparam int REQ_TW = clog2(NREQ);

    logic [REQ_TW-1:0] rr_ptr;
    logic [REQ_TW:0]   cand;
    logic              can_issue;
    logic              grant_vld;
    logic [REQ_TW-1:0] grant_idx;

    logic              fifo_full;
    logic              fifo_empty;
    logic [REQ_TW-1:0] fifo_head;
    logic              rsp_pop;

    // The full test uses the registered count, so a pop in the same cycle
    // cannot open a slot until the next cycle. No grants while in reset.
    assign can_issue = !fifo_full && !rst;
    assign rsp_pop   = mul_valid_out && !fifo_empty;

    // Rotating priority search: first valid requester at or after rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (can_issue) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, rr_ptr} + (REQ_TW+1)'(k);
                if (cand >= (REQ_TW+1)'(NREQ)) begin
                    cand = cand - (REQ_TW+1)'(NREQ);
                end
                if (!grant_vld && req_valid[cand[REQ_TW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[REQ_TW-1:0];
                end
            end
        end
    end

    // req_ready is only raised for a valid candidate, so grant_vld is the transfer.
    assign req_ready = grant_vld ? (NREQ'(1) << grant_idx) : '0;

    booth_tag_fifo #(
        .TAG_W (REQ_TW),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (grant_vld),
        .push_tag (grant_idx),
        .pop      (rsp_pop),
        .pop_tag  (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (inflight)
    );

    // Issue registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr           <= '0;
            mul_valid_in     <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            mul_sign_mode    <= SIGN_UU;
        end else begin
            mul_valid_in <= grant_vld;
            if (grant_vld) begin
                mul_multiplicand <= req_a[grant_idx*WIDTH +: WIDTH];
                mul_multiplier   <= req_b[grant_idx*WIDTH +: WIDTH];
                mul_sign_mode    <= req_mode[grant_idx*2 +: 2];
                rr_ptr           <= (grant_idx == REQ_TW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Return routing: the head tag names the owner of the emerging product.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= '0;
            rsp_product <= '0;
            err_orphan  <= 1'b0;
        end else begin
            rsp_valid <= rsp_pop ? (NREQ'(1) << fifo_head) : '0;
            if (rsp_pop) begin
                rsp_product <= mul_product;
            end
            // A result with nothing outstanding is dropped and flagged.
            if (mul_valid_out && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_rr_scheduler.sv
// Bench for booth_mult_rr_scheduler: behavioural multiplier with programmable
// latency/withhold/inject, scoreboard of {requester, product} filled on each
// transfer and drained on each rsp_valid pulse.
module tb_booth_mult_rr_scheduler;
    import booth_mult_rr_scheduler_pkg::*;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int MAX_OUT = 8;
    localparam int CW      = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*2-1:0]     req_mode;
    logic [NREQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  mul_valid_in;
    logic [WIDTH-1:0]      mul_multiplicand;
    logic [WIDTH-1:0]      mul_multiplier;
    logic [1:0]            mul_sign_mode;
    logic [2*WIDTH-1:0]    mul_product;
    logic                  mul_valid_out;
    logic [CW-1:0]         inflight;
    logic                  err_orphan;

    always #5 clk = ~clk;

    booth_mult_rr_scheduler #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_mode         (req_mode),
        .rsp_valid        (rsp_valid),
        .rsp_product      (rsp_product),
        .mul_valid_in     (mul_valid_in),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_sign_mode    (mul_sign_mode),
        .mul_product      (mul_product),
        .mul_valid_out    (mul_valid_out),
        .inflight         (inflight),
        .err_orphan       (err_orphan)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Golden product: extend each operand to 17 bits per its sign bit, multiply.
    function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] m);
        logic signed [16:0] ea;
        logic signed [16:0] eb;
        logic signed [33:0] p;
        ea = m[1] ? {{9{a[7]}}, a} : {9'b0, a};
        eb = m[0] ? {{9{b[7]}}, b} : {9'b0, b};
        p  = ea * eb;
        return p[15:0];
    endfunction

    // Multiplier model arithmetic (what the real Booth core returns).
    function automatic logic [15:0] mul_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [1:0] m);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic signed [15:0] r;
        sa = m[1] ? 16'($signed(a)) : 16'(a);
        sb = m[0] ? 16'($signed(b)) : 16'(b);
        r  = sa * sb;
        return r;
    endfunction

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] prod;
    } exp_t;

    typedef struct {
        logic [15:0] p;
        int          due;
    } mq_t;

    exp_t        sbq[$];
    mq_t         mq[$];
    int          grant_log[$];
    int          rsp_cnt[NREQ];
    int          rsp_total  = 0;
    int          xfer_cnt   = 0;
    int          cyc        = 0;
    int          lat        = 2;
    logic        hold       = 1'b0;
    logic        inject     = 1'b0;
    logic        log_grants = 1'b0;
    logic [NREQ-1:0] last_rsp_vld  = '0;
    logic [15:0]     last_rsp_prod = '0;

    // Monitor, scoreboard and multiplier model, all on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        mq_t  m;
        int   g;
        cyc++;
        if (rsp_valid != '0) begin
            rsp_total++;
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i]) rsp_cnt[i]++;
            end
            last_rsp_vld  = rsp_valid;
            last_rsp_prod = rsp_product;
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_route", 32'(rsp_valid), 32'(4'b0001 << e.id));
                chk("rsp_prod", 32'(rsp_product), 32'(e.prod));
            end
        end
        if (req_ready != '0) begin
            chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
        end
        if (rst) begin
            sbq.delete();
            mq.delete();
        end else if ((req_valid & req_ready) != '0) begin
            g = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) g = i;
            end
            e.id   = 2'(g);
            e.prod = golden(req_a[g*8 +: 8], req_b[g*8 +: 8], req_mode[g*2 +: 2]);
            sbq.push_back(e);
            xfer_cnt++;
            if (log_grants) grant_log.push_back(g);
        end
        if (mul_valid_in && !rst) begin
            m.p   = mul_model(mul_multiplicand, mul_multiplier, mul_sign_mode);
            m.due = cyc + lat - 1;
            mq.push_back(m);
        end
        mul_valid_out = 1'b0;
        if (inject) begin
            mul_valid_out = 1'b1;
            mul_product   = 16'hDEAD;
        end else if (!hold && mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            mul_valid_out = 1'b1;
            mul_product   = m.p;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] m);
        req_a[i*8 +: 8]    = a;
        req_b[i*8 +: 8]    = b;
        req_mode[i*2 +: 2] = m;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || inflight != '0 || rsp_valid != '0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_done", 32'(sbq.size() == 0 && inflight == '0), 32'd1);
    endtask

    function automatic logic [7:0] rnd_op();
        logic [7:0] corners [4];
        corners[0] = 8'h00;
        corners[1] = 8'h7F;
        corners[2] = 8'h80;
        corners[3] = 8'hFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    initial begin
        int x0;
        int r0;
        int n;
        rst           = 1'b1;
        req_valid     = '0;
        req_a         = '0;
        req_b         = '0;
        req_mode      = '0;
        mul_valid_out = 1'b0;
        mul_product   = '0;
        for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;

        // Reset state, with requests asserted during reset
        repeat (3) step();
        req_valid = '1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_product", 32'(rsp_product), 32'h0);
        chk("rst_mul_valid_in", 32'(mul_valid_in), 32'h0);
        chk("rst_mul_a", 32'(mul_multiplicand), 32'h0);
        chk("rst_mul_b", 32'(mul_multiplier), 32'h0);
        chk("rst_mul_mode", 32'(mul_sign_mode), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_err_orphan", 32'(err_orphan), 32'h0);
        req_valid = '0;
        step();
        rst = 1'b0;

        // Fair rotation: all four requesting for 8 cycles
        lat = 2;
        for (int i = 0; i < NREQ; i++) set_req(i, rnd_op(), rnd_op(), 2'($urandom));
        grant_log.delete();
        log_grants = 1'b1;
        req_valid  = '1;
        repeat (8) step();
        req_valid  = '0;
        log_grants = 1'b0;
        drain();
        chk("rot_grant_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < grant_log.size(); k++) begin
            chk("rot_grant_order", 32'(grant_log[k]), 32'(k % NREQ));
        end
        for (int i = 0; i < NREQ; i++) chk("rot_rsp_count", 32'(rsp_cnt[i]), 32'd2);

        // Routing and sign modes
        set_req(2, 8'hFF, 8'hFF, SIGN_UU);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        drain();
        chk("route_uu_vld", 32'(last_rsp_vld), 32'h4);
        chk("route_uu_prod", 32'(last_rsp_prod), 32'hFE01);
        set_req(1, 8'h80, 8'h80, SIGN_SS);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        drain();
        chk("route_ss_vld", 32'(last_rsp_vld), 32'h2);
        chk("route_ss_prod", 32'(last_rsp_prod), 32'h4000);
        set_req(3, 8'hFF, 8'hFF, SIGN_US);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        drain();
        chk("route_us_vld", 32'(last_rsp_vld), 32'h8);
        chk("route_us_prod", 32'(last_rsp_prod), 32'hFF01);

        // Backpressure on full: results withheld
        lat  = 1;
        hold = 1'b1;
        x0   = xfer_cnt;
        req_valid = '1;
        repeat (12) step();
        chk("full_xfers", 32'(xfer_cnt - x0), 32'd8);
        chk("full_inflight", 32'(inflight), 32'd8);
        chk("full_ready", 32'(req_ready), 32'h0);
        hold = 1'b0;
        @(negedge clk);
        #1;
        chk("full_first_out", 32'(mul_valid_out), 32'd1);
        chk("full_ready_pop_cycle", 32'(req_ready), 32'h0);
        step();
        chk("full_after_pop", 32'(inflight), 32'd7);
        chk("full_resume", 32'(req_ready != '0), 32'd1);
        req_valid = '0;
        drain();

        // Steady state with simultaneous push/pop
        lat = 3;
        req_valid = '1;
        repeat (10) step();
        for (int k = 0; k < 20; k++) begin
            chk("ss_inflight", 32'(inflight), 32'd3);
            chk("ss_mul_valid_in", 32'(mul_valid_in), 32'd1);
            chk("ss_xfer", 32'((req_valid & req_ready) != '0), 32'd1);
            step();
        end
        req_valid = '0;
        drain();

        // Orphan result
        chk("orph_pre", 32'(err_orphan), 32'd0);
        inject = 1'b1;
        @(negedge clk);
        #1;
        inject = 1'b0;
        step();
        chk("orph_set", 32'(err_orphan), 32'd1);
        chk("orph_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("orph_inflight", 32'(inflight), 32'd0);
        chk("orph_prod_hold", 32'(rsp_product), 32'(last_rsp_prod));
        repeat (5) step();
        chk("orph_sticky", 32'(err_orphan), 32'd1);

        // Reset with 5 operations in flight
        hold = 1'b1;
        x0   = xfer_cnt;
        req_valid = '1;
        repeat (5) step();
        req_valid = '0;
        chk("mid_xfers", 32'(xfer_cnt - x0), 32'd5);
        chk("mid_inflight", 32'(inflight), 32'd5);
        req_valid = '1;
        rst  = 1'b1;
        hold = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rsp_product", 32'(rsp_product), 32'h0);
        chk("mid_mul_valid_in", 32'(mul_valid_in), 32'h0);
        chk("mid_mul_a", 32'(mul_multiplicand), 32'h0);
        chk("mid_mul_b", 32'(mul_multiplier), 32'h0);
        chk("mid_mul_mode", 32'(mul_sign_mode), 32'h0);
        chk("mid_inflight0", 32'(inflight), 32'h0);
        chk("mid_err_orphan", 32'(err_orphan), 32'h0);
        chk("mid_next_grant", 32'(req_ready), 32'h1);
        req_valid = '0;

        // 1000 random requests against the golden model
        lat = 3;
        x0  = xfer_cnt;
        r0  = rsp_total;
        n   = 0;
        while ((xfer_cnt - x0) < 1000 && n < 20000) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < NREQ; i++) set_req(i, rnd_op(), rnd_op(), 2'($urandom));
            hold = ($urandom_range(0, 9) == 0);
            step();
            n++;
        end
        req_valid = '0;
        hold      = 1'b0;
        chk("rand_xfers", 32'(xfer_cnt - x0), 32'd1000);
        drain();
        chk("rand_rsps", 32'(rsp_total - r0), 32'd1000);
        chk("rand_no_orphan", 32'(err_orphan), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
